// File: rtl/sqd_pattern_tx.sv
// Serial pattern transmitter: shifts a captured PAT_W-bit pattern out MSB-first,
// repeating it REPEAT times with an optional idle gap between repetitions.
module sqd_pattern_tx #(
  parameter int   PAT_W      = 4,
  parameter int   CNT_W      = 4,
  parameter int   GAP_CYCLES = 0,
  parameter logic IDLE_BIT   = 1'b0
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             LOAD,
  input  logic [PAT_W-1:0] PATTERN,
  input  logic [CNT_W-1:0] REPEAT,
  input  logic             ABORT,
  output logic             X_OUT,
  output logic             BIT_VALID,
  output logic             FRAME_END,
  output logic             BUSY,
  output logic             DONE
);

  localparam int IW = $clog2(PAT_W);
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(PAT_W - 1);
  localparam logic [IW-1:0] PEN_IDX  = IW'(PAT_W - 2);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP} state_t;

  state_t             state_q, state_d;
  logic [PAT_W-1:0]   pat_q, pat_d;
  logic [PAT_W-1:0]   shreg_q, shreg_d;
  logic [CNT_W-1:0]   rep_q, rep_d;
  logic [IW-1:0]      idx_q, idx_d;
  logic [GW-1:0]      gap_q, gap_d;
  logic               x_d, bv_d, fe_d, busy_d, done_d;

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
    state_d = state_q;
    pat_d   = pat_q;
    shreg_d = shreg_q;
    rep_d   = rep_q;
    idx_d   = idx_q;
    gap_d   = gap_q;
    x_d     = IDLE_BIT;
    bv_d    = 1'b0;
    fe_d    = 1'b0;
    busy_d  = 1'b0;
    done_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (LOAD && (REPEAT != '0)) begin
          state_d = S_SEND;
          pat_d   = PATTERN;
          shreg_d = PATTERN;
          rep_d   = REPEAT;
          idx_d   = '0;
          x_d     = PATTERN[PAT_W-1];
          bv_d    = 1'b1;
          busy_d  = 1'b1;
        end
      end

      S_SEND: begin
        if (ABORT) begin
          state_d = S_IDLE;
          rep_d   = '0;
          idx_d   = '0;
          gap_d   = '0;
        end else if (idx_q == LAST_IDX) begin
          if (rep_q > CNT_W'(1)) begin
            rep_d  = rep_q - CNT_W'(1);
            busy_d = 1'b1;
            if (GAP_CYCLES > 0) begin
              state_d = S_GAP;
              gap_d   = '0;
            end else begin
              // Back-to-back: the next frame's MSB follows the previous LSB directly.
              shreg_d = pat_q;
              idx_d   = '0;
              x_d     = pat_q[PAT_W-1];
              bv_d    = 1'b1;
            end
          end else begin
            state_d = S_IDLE;
            rep_d   = '0;
            idx_d   = '0;
            done_d  = 1'b1;
          end
        end else begin
          shreg_d = shreg_q << 1;
          idx_d   = idx_q + IW'(1);
          x_d     = shreg_q[PAT_W-2];
          bv_d    = 1'b1;
          fe_d    = (idx_q == PEN_IDX);
          busy_d  = 1'b1;
        end
      end

      S_GAP: begin
        if (ABORT) begin
          state_d = S_IDLE;
          rep_d   = '0;
          idx_d   = '0;
          gap_d   = '0;
        end else if (gap_q == GAP_LAST) begin
          state_d = S_SEND;
          gap_d   = '0;
          shreg_d = pat_q;
          idx_d   = '0;
          x_d     = pat_q[PAT_W-1];
          bv_d    = 1'b1;
          busy_d  = 1'b1;
        end else begin
          gap_d  = gap_q + GW'(1);
          busy_d = 1'b1;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q   <= S_IDLE;
      pat_q     <= '0;
      shreg_q   <= '0;
      rep_q     <= '0;
      idx_q     <= '0;
      gap_q     <= '0;
      X_OUT     <= IDLE_BIT;
      BIT_VALID <= 1'b0;
      FRAME_END <= 1'b0;
      BUSY      <= 1'b0;
      DONE      <= 1'b0;
    end else begin
      state_q   <= state_d;
      pat_q     <= pat_d;
      shreg_q   <= shreg_d;
      rep_q     <= rep_d;
      idx_q     <= idx_d;
      gap_q     <= gap_d;
      X_OUT     <= x_d;
      BIT_VALID <= bv_d;
      FRAME_END <= fe_d;
      BUSY      <= busy_d;
      DONE      <= done_d;
    end
  end

endmodule
